// File: rtl/mips_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// memory command payload and reset/zero values.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;
    localparam int unsigned WD_W = 8;

    localparam logic [XLEN-1:0] ZERO_WORD = '0;
    localparam logic [BE_W-1:0] ZERO_BE   = '0;
    localparam logic [BE_W-1:0] FULL_BE   = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

    localparam arb_state_t RST_STATE = IDLE;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    localparam mem_cmd_t ZERO_CMD = '0;

    function automatic logic is_busy(input arb_state_t s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// with bounded data bursts, fetch abort and a BUSY watchdog.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_abort,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_stall,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [BE_W-1:0] d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_stall,
    output logic            bus_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned    BURST_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [BURST_W-1:0] burst_q;
    logic [WD_W-1:0]    wd_q;
    logic               abort_q;
    mem_cmd_t           cmd_q;

    logic               grant_i;
    logic               grant_d;
    logic               wd_expired;
    logic               fetch_ok;
    logic               burst_full;
    logic               kill_fetch;
    logic [XLEN-1:0]    resp_data;

    assign fetch_ok   = if_req & ~if_abort;
    assign burst_full = (burst_q == BURST_MAX);
    assign kill_fetch = abort_q | ((state_q == BUSY_I) & if_abort);
    // Writes and watchdog expiries both return a zero word.
    assign resp_data  = (mem_ack && !cmd_q.we) ? mem_rdata : ZERO_WORD;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decode; arbitration only from IDLE.
    always_comb begin
        state_d    = state_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        wd_expired = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_ok && (!d_req || burst_full)) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end else if (d_req) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    state_d = RESP_I;
                end else if (wd_q == WD_LAST) begin
                    wd_expired = 1'b1;
                    state_d    = RESP_I;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d = RESP_D;
                end else if (wd_q == WD_LAST) begin
                    wd_expired = 1'b1;
                    state_d    = RESP_D;
                end
            end
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered datapath: command latch, counters, responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= ZERO_CMD;
            burst_q  <= '0;
            wd_q     <= '0;
            abort_q  <= 1'b0;
            mem_req  <= 1'b0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            bus_err  <= 1'b0;
            if_rdata <= ZERO_WORD;
            d_rdata  <= ZERO_WORD;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= wd_expired;
            mem_req <= is_busy(state_d);
            wd_q    <= (is_busy(state_q) && is_busy(state_d)) ? wd_q + 1'b1 : '0;

            if (grant_i) begin
                cmd_q   <= '{we: 1'b0, be: FULL_BE, addr: if_addr, wdata: ZERO_WORD};
                burst_q <= '0;
            end
            if (grant_d) begin
                cmd_q <= '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
                if (!if_req) begin
                    burst_q <= '0;
                end else if (!burst_full) begin
                    burst_q <= burst_q + 1'b1;
                end
            end

            // An aborted fetch still finishes on the bus but is not delivered.
            if (state_q == BUSY_I && state_d == RESP_I) begin
                cmd_q  <= ZERO_CMD;
                if_ack <= ~kill_fetch;
                if (!kill_fetch) begin
                    if_rdata <= resp_data;
                end
            end
            if (state_q == BUSY_D && state_d == RESP_D) begin
                cmd_q   <= ZERO_CMD;
                d_ack   <= 1'b1;
                d_rdata <= resp_data;
            end

            if (state_q == RESP_I) begin
                abort_q <= 1'b0;
            end else if (state_q == BUSY_I && if_abort) begin
                abort_q <= 1'b1;
            end
        end
    end

    assign mem_we    = cmd_q.we;
    assign mem_be    = cmd_q.be;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_DATA_BURST=4, TIMEOUT=8).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_abort;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .MAX_DATA_BURST(4),
        .TIMEOUT       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_abort (if_abort),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_stall  (d_stall),
        .bus_err  (bus_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] fetch_slot;
        fetch_slot = 10'b1000010000;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_abort = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset values
        #12;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_if_stall", if_stall, 1'b0);
        rst_n = 1'b1;

        // Single fetch, zero-wait memory
        if_req = 1'b1; if_addr = 32'h0040_0000; mem_ack = 1'b1; mem_rdata = 32'h8C08_0004;
        step();
        chk1("f1_mem_req", mem_req, 1'b1);
        chk("f1_mem_addr", mem_addr, 32'h0040_0000);
        chk1("f1_mem_we", mem_we, 1'b0);
        chk1("f1_if_ack_early", if_ack, 1'b0);
        chk1("f1_if_stall", if_stall, 1'b1);
        step();
        chk1("f1_if_ack", if_ack, 1'b1);
        chk("f1_if_rdata", if_rdata, 32'h8C08_0004);
        chk1("f1_mem_req_off", mem_req, 1'b0);
        chk1("f1_if_stall_off", if_stall, 1'b0);
        if_req = 1'b0; mem_ack = 1'b0;
        step();
        chk1("f1_if_ack_pulse", if_ack, 1'b0);
        chk("f1_if_rdata_hold", if_rdata, 32'h8C08_0004);

        // Contention: expect D,D,D,D,I,D,D,D,D,I
        if_req = 1'b1; if_addr = 32'h0040_0100;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0040;
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_rdata = 32'hA5A5_0000 | 32'(i);
            step();
            chk("arb_grant_addr", mem_addr, fetch_slot[i] ? 32'h0040_0100 : 32'h1001_0040);
            step();
            if (fetch_slot[i]) begin
                chk1("arb_if_ack", if_ack, 1'b1);
                chk1("arb_no_d_ack", d_ack, 1'b0);
                chk("arb_if_rdata", if_rdata, 32'hA5A5_0000 | 32'(i));
            end else begin
                chk1("arb_d_ack", d_ack, 1'b1);
                chk1("arb_no_if_ack", if_ack, 1'b0);
                chk("arb_d_rdata", d_rdata, 32'hA5A5_0000 | 32'(i));
            end
            step();
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;

        // Store with two wait cycles
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h1001_0000;
        d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("st_mem_req", mem_req, 1'b1);
            chk1("st_mem_we", mem_we, 1'b1);
            chk("st_mem_be", 32'(mem_be), 32'h3);
            chk("st_mem_addr", mem_addr, 32'h1001_0000);
            chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk1("st_d_ack_early", d_ack, 1'b0);
            chk1("st_d_stall", d_stall, 1'b1);
            if (k == 2) mem_ack = 1'b1;
        end
        step();
        chk1("st_d_ack", d_ack, 1'b1);
        chk("st_d_rdata", d_rdata, 32'h0);
        chk1("st_mem_req_off", mem_req, 1'b0);
        chk("st_mem_addr_off", mem_addr, 32'h0);
        chk1("st_mem_we_off", mem_we, 1'b0);
        chk1("st_d_stall_off", d_stall, 1'b0);
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_wdata = '0; mem_ack = 1'b0;
        step();
        chk1("st_d_ack_pulse", d_ack, 1'b0);

        // Abort in IDLE blocks the fetch grant
        if_req = 1'b1; if_abort = 1'b1; if_addr = 32'h0040_0200;
        step();
        chk1("ab_idle_blocked", mem_req, 1'b0);
        if_abort = 1'b0;
        step();
        chk1("ab_busy_i", mem_req, 1'b1);
        chk("ab_busy_addr", mem_addr, 32'h0040_0200);
        // Abort during BUSY_I with a data request waiting
        if_abort = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0080;
        step();
        chk1("ab_still_busy", mem_req, 1'b1);
        if_abort = 1'b0; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        chk1("ab_no_if_ack", if_ack, 1'b0);
        chk1("ab_resp_mem_req", mem_req, 1'b0);
        mem_rdata = 32'hCAFE_0002;
        step();
        chk1("ab_idle_mem_req", mem_req, 1'b0);
        chk1("ab_idle_d_ack", d_ack, 1'b0);
        step();
        chk1("ab_d_granted", mem_req, 1'b1);
        chk("ab_d_addr", mem_addr, 32'h1001_0080);
        step();
        chk1("ab_d_ack", d_ack, 1'b1);
        chk("ab_d_rdata", d_rdata, 32'hCAFE_0002);
        d_req = 1'b0; mem_ack = 1'b0;
        step();

        // Watchdog: no mem_ack for 8 BUSY cycles
        d_req = 1'b1; d_addr = 32'h1001_0100;
        for (int k = 0; k < 8; k++) begin
            step();
            chk1("wd_mem_req", mem_req, 1'b1);
            chk1("wd_bus_err_early", bus_err, 1'b0);
            chk1("wd_d_ack_early", d_ack, 1'b0);
        end
        step();
        chk1("wd_d_ack", d_ack, 1'b1);
        chk1("wd_bus_err", bus_err, 1'b1);
        chk("wd_d_rdata", d_rdata, 32'h0);
        chk1("wd_mem_req_off", mem_req, 1'b0);
        d_req = 1'b0;
        step();
        chk1("wd_bus_err_pulse", bus_err, 1'b0);
        chk1("wd_d_ack_pulse", d_ack, 1'b0);

        // Reset asserted in the middle of BUSY_D
        d_req = 1'b1; d_addr = 32'h1001_0200;
        step();
        chk1("rb_busy", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rb_mem_req_async", mem_req, 1'b0);
        chk("rb_mem_addr_async", mem_addr, 32'h0);
        chk1("rb_d_ack_async", d_ack, 1'b0);
        d_req = 1'b0; mem_ack = 1'b1;
        step();
        chk1("rb_no_d_ack", d_ack, 1'b0);
        #3;
        rst_n = 1'b1;
        step();
        chk1("rb_idle_mem_req", mem_req, 1'b0);
        chk1("rb_idle_d_ack", d_ack, 1'b0);
        if_req = 1'b1; if_addr = 32'h0040_0300; mem_rdata = 32'h2402_0001;
        step();
        chk1("rb_fetch_busy", mem_req, 1'b1);
        chk("rb_fetch_addr", mem_addr, 32'h0040_0300);
        step();
        chk1("rb_fetch_ack", if_ack, 1'b1);
        chk("rb_fetch_rdata", if_rdata, 32'h2402_0001);
        if_req = 1'b0; mem_ack = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
